// File: rtl/wb_regfile_if.sv
// Writeback/read-port bundle for wb_regfile: MEM/WB inputs, decode read
// addresses, and the read/writeback results returned by the register file.
interface wb_regfile_if #(
    parameter int unsigned COUNT_W = 32
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic [AW-1:0]      mem_wb_rd;
    logic               mem_wb_mem_to_reg;
    logic               mem_wb_regwrite;
    logic [XLEN-1:0]    mem_wb_aluout1;
    logic [XLEN-1:0]    mem_wb_aluout2;
    logic [AW-1:0]      id_rs1;
    logic [AW-1:0]      id_rs2;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    wb_data;
    logic               wb_we;
    logic [COUNT_W-1:0] wb_count;

    modport master (
        output mem_wb_rd, mem_wb_mem_to_reg, mem_wb_regwrite,
        output mem_wb_aluout1, mem_wb_aluout2, id_rs1, id_rs2,
        input  rs1_data, rs2_data, wb_data, wb_we, wb_count
    );

    modport slave (
        input  mem_wb_rd, mem_wb_mem_to_reg, mem_wb_regwrite,
        input  mem_wb_aluout1, mem_wb_aluout2, id_rs1, id_rs2,
        output rs1_data, rs2_data, wb_data, wb_we, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// 32x32 register file with writeback mux, two async read ports and a write counter.
// Optional macro WB_BYPASS_EN: read ports forward same-cycle writeback data.
module wb_regfile #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic [XLEN-1:0]    r_regs [NREG];
    logic [COUNT_W-1:0] r_count;

    logic [XLEN-1:0]    w_wb_data;
    logic               w_wb_we;
    logic [XLEN-1:0]    w_rs1_data;
    logic [XLEN-1:0]    w_rs2_data;

    assign w_wb_data = bus.mem_wb_mem_to_reg ? bus.mem_wb_aluout2 : bus.mem_wb_aluout1;
    assign w_wb_we   = bus.mem_wb_regwrite && (bus.mem_wb_rd != AW'(0)) && !rst;

    // Array update and effective-write counter; reset wins over any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_wb_we) begin
            r_regs[bus.mem_wb_rd] <= w_wb_data;
            r_count               <= r_count + COUNT_W'(1);
        end
    end

    // Read port 1: x0 is hardwired to zero.
    always_comb begin
        w_rs1_data = (bus.id_rs1 == AW'(0)) ? XLEN'(0) : r_regs[bus.id_rs1];
`ifdef WB_BYPASS_EN
        if (w_wb_we && (bus.id_rs1 == bus.mem_wb_rd)) begin
            w_rs1_data = w_wb_data;
        end
`endif
    end

    // Read port 2: identical structure so equal addresses give equal data.
    always_comb begin
        w_rs2_data = (bus.id_rs2 == AW'(0)) ? XLEN'(0) : r_regs[bus.id_rs2];
`ifdef WB_BYPASS_EN
        if (w_wb_we && (bus.id_rs2 == bus.mem_wb_rd)) begin
            w_rs2_data = w_wb_data;
        end
`endif
    end

    assign bus.rs1_data = w_rs1_data;
    assign bus.rs2_data = w_rs2_data;
    assign bus.wb_data  = w_wb_data;
    assign bus.wb_we    = w_wb_we;
    assign bus.wb_count = r_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized self-checking bench for wb_regfile against an array-based reference model.
// Runs a 32-bit-counter instance and a 4-bit-counter instance side by side.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wb_regfile_if #(.COUNT_W(32)) bus ();
    wb_regfile_if #(.COUNT_W(4))  bus4 ();

    assign bus4.mem_wb_rd         = bus.mem_wb_rd;
    assign bus4.mem_wb_mem_to_reg = bus.mem_wb_mem_to_reg;
    assign bus4.mem_wb_regwrite   = bus.mem_wb_regwrite;
    assign bus4.mem_wb_aluout1    = bus.mem_wb_aluout1;
    assign bus4.mem_wb_aluout2    = bus.mem_wb_aluout2;
    assign bus4.id_rs1            = bus.id_rs1;
    assign bus4.id_rs2            = bus.id_rs2;

    wb_regfile #(.COUNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.COUNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Reference state: plain register array and an unbounded-style write tally.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    int unsigned n_vec;
    int unsigned n_miss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] rd, input logic [31:0] wbv);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (we && a == rd) return wbv;
`endif
        return m_regs[a];
    endfunction

    // One clock of stimulus: check combinational outputs, clock, then check counters.
    task automatic apply(input logic r, input logic we, input logic [4:0] rd,
                         input logic m2r, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [4:0] s1, input logic [4:0] s2);
        logic [31:0] wbv;
        logic        wev;
        rst                   = r;
        bus.mem_wb_regwrite   = we;
        bus.mem_wb_rd         = rd;
        bus.mem_wb_mem_to_reg = m2r;
        bus.mem_wb_aluout1    = a1;
        bus.mem_wb_aluout2    = a2;
        bus.id_rs1            = s1;
        bus.id_rs2            = s2;
        wbv = m2r ? a2 : a1;
        wev = we && (rd != 5'd0) && !r;
        #1;
        check("wb_data", bus.wb_data, wbv);
        check("wb_we", 32'(bus.wb_we), 32'(wev));
        check("rs1_data", bus.rs1_data, exp_read(s1, wev, rd, wbv));
        check("rs2_data", bus.rs2_data, exp_read(s2, wev, rd, wbv));
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 32'd0;
        end else if (wev) begin
            m_regs[rd] = wbv;
            m_cnt      = m_cnt + 32'd1;
        end
        #1;
        check("wb_count", bus.wb_count, m_cnt);
        check("wb_count_w4", 32'(bus4.wb_count), m_cnt % 32'd16);
    endtask

    initial begin
        logic [4:0] rd;
        logic [4:0] s1;
        logic [4:0] s2;
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;

        // First reset edge brings the array out of X; second is checked with a write pending.
        rst                   = 1'b1;
        bus.mem_wb_regwrite   = 1'b1;
        bus.mem_wb_rd         = 5'd9;
        bus.mem_wb_mem_to_reg = 1'b0;
        bus.mem_wb_aluout1    = 32'h1111_2222;
        bus.mem_wb_aluout2    = 32'h0;
        bus.id_rs1            = 5'd0;
        bus.id_rs2            = 5'd0;
        @(posedge clk);
        #1;
        apply(1'b1, 1'b1, 5'd9, 1'b0, 32'h1111_2222, 32'h0, 5'd9, 5'd1);

        // All registers read zero after reset.
        for (int i = 1; i < 32; i++) begin
            apply(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(32 - i));
        end
        check("post_reset_count", bus.wb_count, 32'd0);

        // Directed: plain ALU write then read back.
        apply(1'b0, 1'b1, 5'd5, 1'b0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd0);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
        check("x5_direct", bus.rs1_data, 32'hDEAD_BEEF);
        check("count_after_x5", bus.wb_count, 32'd1);

        // Directed: write to x0 is discarded.
        apply(1'b0, 1'b1, 5'd0, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 5'd0);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("x0_direct", bus.rs2_data, 32'd0);
        check("count_after_x0", bus.wb_count, 32'd1);

        // Directed: load write to x7 read on both ports in the same cycle and the next.
        apply(1'b0, 1'b1, 5'd7, 1'b0, 32'h0000_0777, 32'h0, 5'd0, 5'd0);
        apply(1'b0, 1'b1, 5'd7, 1'b1, 32'h0, 32'hCAFE_0001, 5'd7, 5'd7);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd7, 5'd7);
        check("x7_next_cycle", bus.rs1_data, 32'hCAFE_0001);

        // Directed: reset suppresses a concurrent write.
        apply(1'b0, 1'b1, 5'd3, 1'b0, 32'h1, 32'h0, 5'd3, 5'd0);
        apply(1'b1, 1'b1, 5'd3, 1'b0, 32'h55, 32'h0, 5'd3, 5'd3);
        apply(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3);
        check("x3_after_reset", bus.rs1_data, 32'd0);

        // Counter wrap on the narrow instance: 17 effective writes.
        apply(1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 17; i++) begin
            apply(1'b0, 1'b1, 5'((i % 31) + 1), 1'(i % 2), $urandom, $urandom, 5'd0, 5'd0);
        end
        check("count_w4_wrap", 32'(bus4.wb_count), 32'd1);
        check("count_w32_17", bus.wb_count, 32'd17);

        // Random traffic, with reads biased toward the write target.
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            s1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            s2 = ($urandom_range(0, 3) == 0) ? s1 : 5'($urandom_range(0, 31));
            apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rd,
                  1'($urandom), $urandom, $urandom, s1, s2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter COUNT_W, default 32, width of the write-event counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mem_wb_rd  input  5  destination register index from the MEM/WB pipeline register.
REQ-005 mem_wb_mem_to_reg  input  1  1 selects mem_wb_aluout2 (load data); 0 selects mem_wb_aluout1 (ALU result).
REQ-006 mem_wb_regwrite  input  1  write enable for the retiring instruction.
REQ-007 mem_wb_aluout1  input  32  ALU result.
REQ-008 mem_wb_aluout2  input  32  memory read data.
REQ-009 id_rs1, id_rs2  input  5 each  decode-stage read addresses.
REQ-010 rs1_data, rs2_data  output  32 each  read data, combinational from the addresses.
REQ-011 wb_data  output  32  selected writeback value, combinational.
REQ-012 wb_we  output  1  effective write strobe, combinational: mem_wb_regwrite && mem_wb_rd != 0 && !rst.
REQ-013 wb_count  output  COUNT_W  registered count of effective writes.

Function
REQ-014 Storage SHALL be 32 x 32-bit registers; x0 SHALL always read 0 and SHALL never be written.
REQ-015 wb_data SHALL be mem_wb_mem_to_reg ? mem_wb_aluout2 : mem_wb_aluout1.
REQ-016 On posedge clk with wb_we=1, register[mem_wb_rd] SHALL take wb_data; the new value is visible in the array one cycle later.
REQ-017 Inputs with mem_wb_regwrite=0 (pipeline bubble, all-zero MEM/WB contents) SHALL leave the array and wb_count unchanged.
REQ-018 A write with mem_wb_rd=0 SHALL be discarded and SHALL NOT increment wb_count.
REQ-019 wb_count SHALL increment by 1 on each posedge with wb_we=1 and SHALL wrap from 2^COUNT_W-1 to 0 without saturating.
REQ-020 rs1_data and rs2_data SHALL be asynchronous reads of the array (zero-latency), subject to REQ-024.
REQ-021 The same index on both read ports SHALL return identical data.

Reset
REQ-022 While rst=1 at a posedge, all 32 registers and wb_count SHALL become 0, and any concurrent write SHALL be suppressed.
REQ-023 After reset, rs1_data, rs2_data, and wb_count SHALL read 0 until the first effective write; wb_data remains combinational and unaffected by reset.

Configuration
REQ-024 When macro WB_BYPASS_EN is defined, each read port SHALL return wb_data when wb_we=1 and its address equals mem_wb_rd (write-through, same cycle); when undefined, read ports SHALL return array contents only, so the written value appears one cycle after the write edge.

Verification
REQ-025 rst=1 for 2 cycles, then release; read x1..x31 -> every value is 0, and wb_count=0.
REQ-026 regwrite=1, rd=5, mem_to_reg=0, aluout1=0xDEADBEEF; next cycle, id_rs1=5 -> rs1_data=0xDEADBEEF and wb_count=1.
REQ-027 regwrite=1, rd=0, aluout1=0x12345678 -> id_rs2=0 reads 0 and wb_count is unchanged.
REQ-028 regwrite=1, rd=7, mem_to_reg=1, aluout2=0xCAFE0001, id_rs1=id_rs2=7 in the same cycle -> with WB_BYPASS_EN both read ports return 0xCAFE0001; without it, both return the old x7 value, then 0xCAFE0001 on the next cycle.
REQ-029 Write x3=0x1, assert rst with regwrite=1, rd=3, aluout1=0x55 -> after the edge x3=0 and wb_count=0.
REQ-030 COUNT_W=4, apply 17 consecutive effective writes -> wb_count=1 (wrap verified).
